// File: rtl/alu_req_responder.sv
// alu_req_responder: ALU request responder feeding an in-order result FIFO; `define ALU_RSP_SEQ_EN adds rsp_seq tagging
module alu_req_responder #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_z
`ifdef ALU_RSP_SEQ_EN
    ,
    output logic [7:0]       rsp_seq
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [WIDTH-1:0] alu_f;
    logic [WIDTH-1:0] f_mem [DEPTH];
    logic [DEPTH-1:0] z_mem;
    always_comb begin
        alu_f = req_op == 4'b0000 ? req_a & req_b :
                req_op == 4'b0001 ? req_a | req_b :
                req_op == 4'b0010 ? req_a + req_b :
                req_op == 4'b0110 ? req_a - req_b :
                req_op == 4'b0111 ? req_b :
                req_op == 4'b1100 ? ~(req_a | req_b) : '0;
        push    = req_valid && req_ready;
        pop     = rsp_valid && rsp_ready;
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = push && !pop ? count_q + CW'(1) :
                  !push && pop ? count_q - CW'(1) : count_q;
    end
    // Ready depends only on occupancy, so a full FIFO refuses even during a pop
    assign req_ready = count_q != CW'(DEPTH);
    assign rsp_valid = count_q != '0;
    assign rsp_f     = rsp_valid ? f_mem[rptr_q] : '0;
    assign rsp_z     = rsp_valid ? z_mem[rptr_q] : 1'b0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            f_mem[wptr_q] <= alu_f;
            z_mem[wptr_q] <= alu_f == '0;
        end
    end
`ifdef ALU_RSP_SEQ_EN
    logic [7:0] seq_q, seq_d;
    logic [7:0] seq_mem [DEPTH];
    assign seq_d   = push ? seq_q + 8'd1 : seq_q;
    assign rsp_seq = rsp_valid ? seq_mem[rptr_q] : 8'd0;
    always_ff @(posedge clk) begin
        if (rst)
            seq_q <= 8'd0;
        else
            seq_q <= seq_d;
    end
    always_ff @(posedge clk) begin
        if (push)
            seq_mem[wptr_q] <= seq_q;
    end
`endif
endmodule

// File: tb/tb_alu_req_responder.sv
// tb_alu_req_responder: queue-model scoreboard plus directed literal checks for alu_req_responder
module tb_alu_req_responder;
    localparam int W = 64;
    localparam int D = 4;
    logic         clk = 0;
    logic         rst = 1;
    logic         req_valid = 0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [3:0]   req_op = '0;
    logic         rsp_valid;
    logic         rsp_ready = 0;
    logic [W-1:0] rsp_f;
    logic         rsp_z;
    logic [7:0]   seq_out;
    int           checks = 0;
    int           failures = 0;
    bit           chk_en = 0;

    typedef struct {
        logic [W-1:0] f;
        logic         z;
        logic [7:0]   s;
    } ent_t;
    ent_t       mq[$];
    logic [7:0] mseq = 0;

    alu_req_responder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_z(rsp_z)
`ifdef ALU_RSP_SEQ_EN
        , .rsp_seq(seq_out)
`endif
    );
`ifndef ALU_RSP_SEQ_EN
    assign seq_out = 8'd0;
`endif

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue updated from the same inputs the DUT sees
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mseq = 0;
        end else begin
            automatic bit do_pop  = rsp_ready && mq.size() > 0;
            automatic bit do_push = req_valid && mq.size() < D;
            automatic logic [W-1:0] f = alu(req_a, req_b, req_op);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{f: f, z: f == '0, s: mseq});
                mseq = mseq + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, mq.size() != D});
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, mq.size() != 0});
            chk("rsp_f", rsp_f, mq.size() ? mq[0].f : '0);
            chk("rsp_z", {63'd0, rsp_z}, {63'd0, mq.size() ? mq[0].z : 1'b0});
`ifdef ALU_RSP_SEQ_EN
            chk("rsp_seq", {56'd0, seq_out}, {56'd0, mq.size() ? mq[0].s : 8'd0});
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        req_valid = v;
        req_a = a;
        req_b = b;
        req_op = op;
    endtask

    initial begin
        repeat (2) cyc();
        rst = 0;
        chk_en = 1;
        cyc();
        chk("reset req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset rsp_f", rsp_f, 64'd0);
        chk("reset rsp_seq", {56'd0, seq_out}, 64'd0);

        req(1, 64'd1, 64'd654, 4'b1100);
        cyc();
        req(0, '0, '0, '0);
        chk("nor valid", {63'd0, rsp_valid}, 64'd1);
        chk("nor f", rsp_f, 64'hFFFF_FFFF_FFFF_FD70);
        chk("nor z", {63'd0, rsp_z}, 64'd0);
        rsp_ready = 1;
        cyc();

        req(1, 64'd9, 64'd564, 4'b0001); cyc(); chk("or f", rsp_f, 64'd573);
        req(1, 64'd4, 64'd788, 4'b0010); cyc(); chk("add f", rsp_f, 64'd792);
        req(1, 64'd6, 64'd549, 4'b0110); cyc(); chk("sub f", rsp_f, 64'hFFFF_FFFF_FFFF_FDE1);
        req(1, 64'd2, 64'd567, 4'b0111); cyc(); chk("passb f", rsp_f, 64'd567);
        req(1, 64'd0, 64'd265, 4'b0000); cyc(); chk("and z", {63'd0, rsp_z}, 64'd1);
        req(1, 64'd5, 64'd7, 4'b1111); cyc();
        chk("undef f", rsp_f, 64'd0);
        chk("undef z", {63'd0, rsp_z}, 64'd1);
        req(0, '0, '0, '0);
        cyc();

        rsp_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            req(1, 64'(i), 64'(10 * i), 4'b0010);
            cyc();
        end
        chk("full ready", {63'd0, req_ready}, 64'd0);
        req(1, 64'd5, 64'd50, 4'b0010);
        cyc();
        chk("held head", rsp_f, 64'd11);
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        chk("pop ready", {63'd0, req_ready}, 64'd1);
        chk("pop head", rsp_f, 64'd22);
        cyc();
        req(0, '0, '0, '0);
        chk("refill ready", {63'd0, req_ready}, 64'd0);
        rsp_ready = 1;
        repeat (3) cyc();
        chk("last head", rsp_f, 64'd55);
        cyc();
        chk("drained", {63'd0, rsp_valid}, 64'd0);

        rsp_ready = 0;
        req(1, 64'd100, 64'd1, 4'b0010); cyc();
        req(1, 64'd100, 64'd2, 4'b0010); cyc();
        rsp_ready = 1;
        req(1, 64'd100, 64'd3, 4'b0010); cyc();
        chk("pushpop head", rsp_f, 64'd102);
        chk("pushpop ready", {63'd0, req_ready}, 64'd1);
        req(0, '0, '0, '0);
        repeat (3) cyc();

        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            req(1, 64'(i), 64'd1, 4'b0001);
            cyc();
        end
        rst = 1;
        req(1, 64'd7, 64'd7, 4'b0010);
        cyc();
        rst = 0;
        req(0, '0, '0, '0);
        chk("rst valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst ready", {63'd0, req_ready}, 64'd1);
        cyc();
        chk("rst discard", {63'd0, rsp_valid}, 64'd0);

        rsp_ready = 1;
        for (int i = 0; i < 258; i++) begin
            req(1, 64'd0, 64'(i + 1), 4'b0111);
            cyc();
`ifdef ALU_RSP_SEQ_EN
            chk("seq wrap", {56'd0, seq_out}, 64'(i % 256));
`else
            if (i == 257) chk("stream f", rsp_f, 64'd258);
`endif
        end
        req(0, '0, '0, '0);
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
